wbu_commit: RTL and testbench

//  Writeback/commit stage downstream of the LSU. Accepts one retired instruction per o_valid

---
 rtl/wbu_commit_pkg.sv | 20 ++
 rtl/wbu_csr_file.sv | 69 ++++++
 rtl/wbu_commit.sv | 87 ++++++++
 tb/tb_wbu_commit.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/wbu_commit_pkg.sv
// wbu_commit_pkg: CSR addresses, csr_t encoding, cause codes and mstatus bit positions
package wbu_commit_pkg;
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  typedef enum logic [1:0] {
    CSR_NONE  = 2'b00,
    CSR_WRITE = 2'b01,
    CSR_ECALL = 2'b10,
    CSR_MRET  = 2'b11
  } csr_t_e;
  localparam logic [31:0] MCAUSE_ECALL_M = 32'd11;
  localparam int MSTATUS_MIE  = 3;
  localparam int MSTATUS_MPIE = 7;
endpackage

// File: rtl/wbu_csr_file.sv
// wbu_csr_file: M-mode CSR storage, 64-bit counters and combinational read port
module wbu_csr_file
  import wbu_commit_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC   = 32'h0000_0000,
  parameter logic [31:0] MSTATUS_RESET = 32'h0000_1800
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_trap,
  input  logic        i_mret,
  input  logic        i_wen,
  input  logic        i_retire,
  input  logic [11:0] i_waddr,
  input  logic [31:0] i_wdata,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_cause,
  input  logic [11:0] i_raddr,
  output logic [31:0] o_rdata,
  output logic [31:0] o_trap_vec,
  output logic [31:0] o_mepc
);
  logic [31:0] mstatus, mtvec, mepc, mcause;
  logic [63:0] mcycle, minstret, mcycle_n, minstret_n;
  always_comb begin
    mcycle_n   = (i_wen && i_waddr == CSR_MCYCLE)    ? {mcycle[63:32], i_wdata} :
                 (i_wen && i_waddr == CSR_MCYCLEH)   ? {i_wdata, mcycle[31:0]} : mcycle + 64'd1;
    minstret_n = (i_wen && i_waddr == CSR_MINSTRET)  ? {minstret[63:32], i_wdata} :
                 (i_wen && i_waddr == CSR_MINSTRETH) ? {i_wdata, minstret[31:0]} :
                 minstret + {63'd0, i_retire};
    o_rdata    = i_raddr == CSR_MSTATUS   ? mstatus :
                 i_raddr == CSR_MTVEC     ? mtvec :
                 i_raddr == CSR_MEPC      ? mepc :
                 i_raddr == CSR_MCAUSE    ? mcause :
                 i_raddr == CSR_MCYCLE    ? mcycle[31:0] :
                 i_raddr == CSR_MCYCLEH   ? mcycle[63:32] :
                 i_raddr == CSR_MINSTRET  ? minstret[31:0] :
                 i_raddr == CSR_MINSTRETH ? minstret[63:32] : 32'd0;
  end
  assign o_trap_vec = {mtvec[31:2], 2'b00};
  assign o_mepc     = mepc;
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      mstatus  <= MSTATUS_RESET;
      mtvec    <= RESET_MTVEC;
      mepc     <= 32'd0;
      mcause   <= 32'd0;
      mcycle   <= 64'd0;
      minstret <= 64'd0;
    end else begin
      mcycle   <= mcycle_n;
      minstret <= minstret_n;
      if (i_trap) begin
        mepc                  <= i_pc;
        mcause                <= i_cause;
        mstatus[MSTATUS_MPIE] <= mstatus[MSTATUS_MIE];
        mstatus[MSTATUS_MIE]  <= 1'b0;
      end else if (i_mret) begin
        mstatus[MSTATUS_MIE]  <= mstatus[MSTATUS_MPIE];
        mstatus[MSTATUS_MPIE] <= 1'b1;
      end else if (i_wen) begin
        if (i_waddr == CSR_MSTATUS) mstatus <= i_wdata;
        if (i_waddr == CSR_MTVEC)   mtvec   <= i_wdata;
        if (i_waddr == CSR_MEPC)    mepc    <= {i_wdata[31:2], 2'b00};
        if (i_waddr == CSR_MCAUSE)  mcause  <= i_wdata;
      end
    end
  end
endmodule

// File: rtl/wbu_commit.sv
// wbu_commit: writeback/commit stage performing GPR writes, CSR updates, traps, mret and redirects
module wbu_commit
  import wbu_commit_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC   = 32'h0000_0000,
  parameter logic [31:0] MSTATUS_RESET = 32'h0000_1800
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_upc,
  input  logic [31:0] i_result,
  input  logic [4:0]  i_reg_rd,
  input  logic        i_reg_wen,
  input  logic [1:0]  i_csr_t,
  input  logic [11:0] i_csr,
  input  logic [31:0] i_csr_wdata,
  input  logic        i_exception,
  input  logic [3:0]  i_mcause,
  input  logic        i_jump,
  input  logic        i_branch,
  input  logic [11:0] i_csr_raddr,
  output logic [31:0] o_csr_rdata,
  output logic        o_rf_wen,
  output logic [4:0]  o_rf_waddr,
  output logic [31:0] o_rf_wdata,
  output logic        o_redirect,
  output logic [31:0] o_redirect_pc,
  output logic        o_commit,
  output logic [31:0] o_commit_pc
);
  logic        acc, trap, mret, cwr, redir;
  logic [31:0] trap_vec, mepc, target, cause;
  always_comb begin
    acc    = i_valid && o_ready;
    trap   = acc && (i_exception || i_csr_t == CSR_ECALL);
    mret   = acc && !trap && i_csr_t == CSR_MRET;
    cwr    = acc && !trap && i_csr_t == CSR_WRITE;
    redir  = trap || mret || (acc && (i_jump || i_branch));
    target = trap ? trap_vec : mret ? mepc : i_upc;
    cause  = i_csr_t == CSR_ECALL ? MCAUSE_ECALL_M : {28'd0, i_mcause};
  end
  wbu_csr_file #(
    .RESET_MTVEC  (RESET_MTVEC),
    .MSTATUS_RESET(MSTATUS_RESET)
  ) u_csr (
    .i_clock   (i_clock),
    .i_reset   (i_reset),
    .i_trap    (trap),
    .i_mret    (mret),
    .i_wen     (cwr),
    .i_retire  (acc && !trap),
    .i_waddr   (i_csr),
    .i_wdata   (i_csr_wdata),
    .i_pc      (i_pc),
    .i_cause   (cause),
    .i_raddr   (i_csr_raddr),
    .o_rdata   (o_csr_rdata),
    .o_trap_vec(trap_vec),
    .o_mepc    (mepc)
  );
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      o_ready       <= 1'b0;
      o_rf_wen      <= 1'b0;
      o_rf_waddr    <= 5'd0;
      o_rf_wdata    <= 32'd0;
      o_redirect    <= 1'b0;
      o_redirect_pc <= 32'd0;
      o_commit      <= 1'b0;
      o_commit_pc   <= 32'd0;
    end else begin
      o_ready    <= !redir;
      o_rf_wen   <= acc && i_reg_wen && !trap && |i_reg_rd;
      o_redirect <= redir;
      o_commit   <= acc && !trap;
      if (acc) begin
        o_rf_waddr    <= i_reg_rd;
        o_rf_wdata    <= i_result;
        o_redirect_pc <= target;
        o_commit_pc   <= i_pc;
      end
    end
  end
endmodule

// File: tb/tb_wbu_commit.sv
// tb_wbu_commit: directed and randomized checks of wbu_commit against a behavioural model
module tb_wbu_commit;
  logic        i_clock, i_reset, i_valid, o_ready;
  logic [31:0] i_pc, i_upc, i_result, i_csr_wdata, o_csr_rdata, o_rf_wdata, o_redirect_pc, o_commit_pc;
  logic [4:0]  i_reg_rd, o_rf_waddr;
  logic        i_reg_wen, i_exception, i_jump, i_branch, o_rf_wen, o_redirect, o_commit;
  logic [1:0]  i_csr_t;
  logic [11:0] i_csr, i_csr_raddr;
  logic [3:0]  i_mcause;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_mstatus, m_mtvec, m_mepc, m_mcause;
  logic [63:0] m_mcycle, m_minstret;
  logic        m_ready, m_in_reset;
  logic        e_rf_wen, e_redirect, e_commit;
  logic [4:0]  e_waddr;
  logic [31:0] e_wdata, e_redirect_pc, e_commit_pc;
  logic [11:0] addrs [10] = '{12'h300, 12'h305, 12'h341, 12'h342, 12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'h301, 12'hF14};
  wbu_commit dut (
    .i_clock(i_clock), .i_reset(i_reset), .i_valid(i_valid), .o_ready(o_ready),
    .i_pc(i_pc), .i_upc(i_upc), .i_result(i_result), .i_reg_rd(i_reg_rd), .i_reg_wen(i_reg_wen),
    .i_csr_t(i_csr_t), .i_csr(i_csr), .i_csr_wdata(i_csr_wdata), .i_exception(i_exception),
    .i_mcause(i_mcause), .i_jump(i_jump), .i_branch(i_branch), .i_csr_raddr(i_csr_raddr),
    .o_csr_rdata(o_csr_rdata), .o_rf_wen(o_rf_wen), .o_rf_waddr(o_rf_waddr), .o_rf_wdata(o_rf_wdata),
    .o_redirect(o_redirect), .o_redirect_pc(o_redirect_pc), .o_commit(o_commit), .o_commit_pc(o_commit_pc)
  );
  initial begin
    i_clock = 0;
    forever #5 i_clock = ~i_clock;
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return m_mstatus;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'hB00: return m_mcycle[31:0];
      12'hB80: return m_mcycle[63:32];
      12'hB02: return m_minstret[31:0];
      12'hB82: return m_minstret[63:32];
      default: return 32'd0;
    endcase
  endfunction
  task automatic model_step();
    logic acc, is_trap, is_mret, is_ecall;
    logic [63:0] cyc, ins;
    if (i_reset) begin
      m_mstatus = 32'h1800; m_mtvec = 32'd0; m_mepc = 32'd0; m_mcause = 32'd0;
      m_mcycle = 64'd0; m_minstret = 64'd0; m_ready = 0; m_in_reset = 1;
      e_rf_wen = 0; e_redirect = 0; e_commit = 0;
      e_waddr = 0; e_wdata = 0; e_redirect_pc = 0; e_commit_pc = 0;
      return;
    end
    m_in_reset = 0;
    acc      = i_valid && m_ready;
    is_ecall = i_csr_t == 2'b10;
    is_trap  = acc && (i_exception || is_ecall);
    is_mret  = acc && !is_trap && i_csr_t == 2'b11;
    e_commit = acc && !is_trap;
    e_rf_wen = acc && !is_trap && i_reg_wen && i_reg_rd != 5'd0;
    e_redirect = is_trap || is_mret || (acc && (i_jump || i_branch));
    if (acc) begin
      e_waddr = i_reg_rd; e_wdata = i_result; e_commit_pc = i_pc;
      if (is_trap) e_redirect_pc = m_mtvec & 32'hFFFF_FFFC;
      else if (is_mret) e_redirect_pc = m_mepc;
      else e_redirect_pc = i_upc;
    end
    cyc = m_mcycle + 1;
    ins = m_minstret + (e_commit ? 64'd1 : 64'd0);
    if (is_trap) begin
      m_mepc = i_pc;
      m_mcause = is_ecall ? 32'd11 : {28'd0, i_mcause};
      m_mstatus[7] = m_mstatus[3];
      m_mstatus[3] = 0;
    end else if (is_mret) begin
      m_mstatus[3] = m_mstatus[7];
      m_mstatus[7] = 1;
    end else if (acc && i_csr_t == 2'b01) begin
      case (i_csr)
        12'h300: m_mstatus = i_csr_wdata;
        12'h305: m_mtvec = i_csr_wdata;
        12'h341: m_mepc = i_csr_wdata & 32'hFFFF_FFFC;
        12'h342: m_mcause = i_csr_wdata;
        12'hB00: cyc = {m_mcycle[63:32], i_csr_wdata};
        12'hB80: cyc = {i_csr_wdata, m_mcycle[31:0]};
        12'hB02: ins = {m_minstret[63:32], i_csr_wdata};
        12'hB82: ins = {i_csr_wdata, m_minstret[31:0]};
        default: ;
      endcase
    end
    m_mcycle = cyc;
    m_minstret = ins;
    m_ready = !e_redirect;
  endtask
  task automatic tick();
    logic [11:0] a;
    model_step();
    @(posedge i_clock);
    #1;
    chk("ready", o_ready, m_ready);
    chk("rf_wen", o_rf_wen, e_rf_wen);
    chk("redirect", o_redirect, e_redirect);
    chk("commit", o_commit, e_commit);
    if (e_rf_wen || m_in_reset) begin
      chk("rf_waddr", o_rf_waddr, e_waddr);
      chk("rf_wdata", o_rf_wdata, e_wdata);
    end
    if (e_redirect || m_in_reset) chk("redirect_pc", o_redirect_pc, e_redirect_pc);
    if (e_commit || m_in_reset) chk("commit_pc", o_commit_pc, e_commit_pc);
    a = addrs[$urandom_range(0, 9)];
    i_csr_raddr = a;
    #1;
    chk("csr_rdata", o_csr_rdata, m_read(a));
  endtask
  task automatic rdc(input string tag, input logic [11:0] a, input logic [31:0] exp);
    i_csr_raddr = a;
    #1;
    chk(tag, o_csr_rdata, exp);
  endtask
  task automatic issue(input logic [31:0] pc, input logic [1:0] ct, input logic [11:0] csr,
                       input logic [31:0] cw, input logic [4:0] rd, input logic wen,
                       input logic [31:0] res, input logic exc, input logic jmp, input logic [31:0] upc);
    i_valid = 1; i_pc = pc; i_csr_t = ct; i_csr = csr; i_csr_wdata = cw; i_reg_rd = rd;
    i_reg_wen = wen; i_result = res; i_exception = exc; i_jump = jmp; i_upc = upc;
    i_mcause = 4'd2; i_branch = 0;
    tick();
    i_valid = 0;
  endtask
  initial begin
    logic [31:0] prev;
    i_reset = 1; i_valid = 1; i_pc = 32'h40; i_upc = 0; i_result = 32'h55; i_reg_rd = 1;
    i_reg_wen = 1; i_csr_t = 0; i_csr = 0; i_csr_wdata = 0; i_exception = 0; i_mcause = 0;
    i_jump = 1; i_branch = 0; i_csr_raddr = 0;
    tick();
    tick();
    chk("rst_ready", o_ready, 0);
    chk("rst_commit", o_commit, 0);
    rdc("rst_mstatus", 12'h300, 32'h1800);
    rdc("rst_mcycle", 12'hB00, 32'd0);
    i_reset = 0; i_valid = 0; i_jump = 0;
    tick();
    tick();
    chk("ready_after_rst", o_ready, 1);
    issue(32'h8000_0000, 2'b00, 12'h0, 32'h0, 5'd5, 1, 32'h1234, 0, 0, 32'h0);
    chk("addi_wen", o_rf_wen, 1);
    chk("addi_waddr", o_rf_waddr, 5);
    chk("addi_wdata", o_rf_wdata, 32'h1234);
    chk("addi_commit", o_commit, 1);
    tick();
    chk("addi_deassert", o_commit, 0);
    prev = m_minstret[31:0];
    issue(32'h8000_0004, 2'b00, 12'h0, 32'h0, 5'd0, 1, 32'hFFFF, 0, 0, 32'h0);
    chk("x0_wen", o_rf_wen, 0);
    chk("x0_commit", o_commit, 1);
    rdc("x0_minstret", 12'hB02, prev + 1);
    issue(32'h8000_0008, 2'b01, 12'h305, 32'h8000_0100, 5'd0, 0, 32'h0, 0, 0, 32'h0);
    issue(32'h8000_000C, 2'b01, 12'h300, 32'h0000_1808, 5'd0, 0, 32'h0, 0, 0, 32'h0);
    issue(32'h8000_0010, 2'b10, 12'h0, 32'h0, 5'd3, 1, 32'h77, 0, 0, 32'h0);
    chk("ecall_redirect", o_redirect, 1);
    chk("ecall_pc", o_redirect_pc, 32'h8000_0100);
    chk("ecall_wen", o_rf_wen, 0);
    chk("ecall_ready", o_ready, 0);
    rdc("ecall_mepc", 12'h341, 32'h8000_0010);
    rdc("ecall_mcause", 12'h342, 32'd11);
    rdc("ecall_mstatus", 12'h300, 32'h0000_1880);
    tick();
    issue(32'h8000_0100, 2'b01, 12'h341, 32'h8000_0014, 5'd0, 0, 32'h0, 0, 0, 32'h0);
    issue(32'h8000_0104, 2'b11, 12'h0, 32'h0, 5'd0, 0, 32'h0, 0, 0, 32'h0);
    chk("mret_redirect", o_redirect, 1);
    chk("mret_pc", o_redirect_pc, 32'h8000_0014);
    rdc("mret_mstatus", 12'h300, 32'h0000_1888);
    tick();
    issue(32'h8000_0020, 2'b00, 12'h0, 32'h0, 5'd4, 1, 32'h9, 1, 1, 32'h8000_0200);
    chk("jmpexc_pc", o_redirect_pc, 32'h8000_0100);
    chk("jmpexc_commit", o_commit, 0);
    rdc("jmpexc_mcause", 12'h342, 32'd2);
    tick();
    issue(32'h8000_0100, 2'b01, 12'hB02, 32'hFFFF_FFFF, 5'd0, 0, 32'h0, 0, 0, 32'h0);
    issue(32'h8000_0104, 2'b00, 12'h0, 32'h0, 5'd1, 1, 32'h1, 0, 0, 32'h0);
    rdc("carry_lo", 12'hB02, 32'd0);
    rdc("carry_hi", 12'hB82, 32'd1);
    for (int n = 0; n < 400; n++) begin
      i_valid = ($urandom % 10) < 7;
      i_pc = $urandom & 32'hFFFF_FFFC; i_upc = $urandom; i_result = $urandom;
      i_reg_rd = 5'($urandom); i_reg_wen = 1'($urandom); i_csr_t = 2'($urandom);
      i_csr = addrs[$urandom_range(0, 9)]; i_csr_wdata = $urandom;
      i_exception = ($urandom % 8) == 0; i_mcause = 4'($urandom);
      i_jump = ($urandom % 8) == 0; i_branch = ($urandom % 8) == 0;
      tick();
    end
    i_valid = 1; i_jump = 1; i_reg_wen = 1; i_reg_rd = 7; i_reset = 1;
    tick();
    chk("midrst_commit", o_commit, 0);
    chk("midrst_redirect", o_redirect, 0);
    rdc("midrst_minstret", 12'hB02, 32'd0);
    rdc("midrst_mepc", 12'h341, 32'd0);
    i_reset = 0; i_valid = 0; i_jump = 0;
    tick();
    chk("midrst_nopulse", o_commit, 0);
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
